// File: rtl/line_cache_if.sv
// CPU request/response, refill and write-back signals of line_cache.
// The cache side uses the slave modport, and the CPU/memory side uses master.
interface line_cache_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16
);
  logic                         inv;
  logic                         req_valid;
  logic                         req_write;
  logic [ADDR_W-1:0]            req_addr;
  logic [DATA_W-1:0]            req_wdata;
  logic                         req_ready;
  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         cache_miss;
  logic                         refill_req;
  logic [ADDR_W-1:0]            refill_addr;
  logic                         refill_valid;
  logic [LINE_WORDS*DATA_W-1:0] refill_data;
  logic                         wb_valid;
  logic                         wb_ready;
  logic [ADDR_W-1:0]            wb_addr;
  logic [DATA_W-1:0]            wb_data;
  logic                         wb_full;
  logic                         wb_empty;

  modport slave (
    input  inv, req_valid, req_write, req_addr, req_wdata,
           refill_valid, refill_data, wb_ready,
    output req_ready, rsp_valid, rsp_rdata, cache_miss, refill_req, refill_addr,
           wb_valid, wb_addr, wb_data, wb_full, wb_empty
  );

  modport master (
    output inv, req_valid, req_write, req_addr, req_wdata,
           refill_valid, refill_data, wb_ready,
    input  req_ready, rsp_valid, rsp_rdata, cache_miss, refill_req, refill_addr,
           wb_valid, wb_addr, wb_data, wb_full, wb_empty
  );
endinterface

// File: rtl/line_cache.sv
// Direct-mapped cache with write-through, no-allocate writes.
// It has one outstanding request and a small write-back FIFO toward memory.
// Refills wait until the FIFO drains, so a fetched line never misses a pending write.
module line_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int INDEX_W    = 8,
  parameter int WB_DEPTH   = 4
) (
  input  logic        cache_clk,
  input  logic        rst,
  line_cache_if.slave bus
);
  localparam int OB    = $clog2(DATA_W / 8);
  localparam int LB    = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OB - LB - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int PTR_W = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, COMPARE, REFILL} state_t;
  state_t state, state_nxt;

  // Request latched at acceptance
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_write;
  logic [DATA_W-1:0]  lat_wdata;
  logic [INDEX_W-1:0] lat_index;
  logic [TAG_W-1:0]   lat_tag;
  logic [LB-1:0]      lat_word;

  // Cache arrays
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DATA_W-1:0]  line_mem [LINES][LINE_WORDS];

  // Write-back FIFO
  logic [ADDR_W-1:0]  wb_addr_mem [WB_DEPTH];
  logic [DATA_W-1:0]  wb_data_mem [WB_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     wb_count;

  logic hit, accept, fill, push, pop, inv_all;
  logic req_ready, rsp_valid, cache_miss, refill_req, wb_empty, wb_full;

  assign lat_index = lat_addr[OB+LB+INDEX_W-1:OB+LB];
  assign lat_tag   = lat_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign lat_word  = lat_addr[OB+LB-1:OB];
  assign hit       = valid[lat_index] && (tag_mem[lat_index] == lat_tag);

  assign wb_empty  = rst || (wb_count == '0);
  assign wb_full   = !rst && (wb_count == (PTR_W+1)'(WB_DEPTH));
  assign accept    = bus.req_valid && req_ready;
  assign fill      = refill_req && bus.refill_valid;
  assign pop       = !wb_empty && bus.wb_ready;
  assign inv_all   = (state == IDLE) && bus.inv;

  // State register
  always_ff @(posedge cache_clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = COMPARE;
      COMPARE: state_nxt = (lat_write || hit) ? IDLE : REFILL;
      REFILL:  if (fill) state_nxt = COMPARE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore/Mealy outputs, all forced quiet while reset is held
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    cache_miss = 1'b0;
    refill_req = 1'b0;
    push       = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:    req_ready = !bus.inv && !(bus.req_write && wb_full);
        COMPARE: begin
          if (lat_write) begin
            rsp_valid = 1'b1;
            push      = 1'b1;
          end else if (hit) begin
            rsp_valid = 1'b1;
          end else begin
            cache_miss = 1'b1;
          end
        end
        REFILL:  refill_req = wb_empty;
        default: ;
      endcase
    end
  end

  // Capture the accepted request
  always_ff @(posedge cache_clk) begin
    if (accept) begin
      lat_addr  <= bus.req_addr;
      lat_write <= bus.req_write;
      lat_wdata <= bus.req_wdata;
    end
  end

  // Valid bits: reset, bulk invalidate, set on refill
  always_ff @(posedge cache_clk) begin
    if (rst)          valid <= '0;
    else if (inv_all) valid <= '0;
    else if (fill)    valid[lat_index] <= 1'b1;
  end

  // Tag and line storage: refill installs a line, and a write hit patches one word
  always_ff @(posedge cache_clk) begin
    // NOTE: storage arrays have no reset; valid bits and FIFO pointers qualify their contents.
    if (fill) begin
      tag_mem[lat_index] <= lat_tag;
      for (int w = 0; w < LINE_WORDS; w++)
        line_mem[lat_index][w] <= bus.refill_data[w*DATA_W +: DATA_W];
    end else if (push && hit) begin
      line_mem[lat_index][lat_word] <= lat_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at WB_DEPTH
  always_ff @(posedge cache_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO entry storage
  always_ff @(posedge cache_clk) begin
    if (push) begin
      wb_addr_mem[wr_ptr] <= lat_addr;
      wb_data_mem[wr_ptr] <= lat_wdata;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = line_mem[lat_index][lat_word];
  assign bus.cache_miss  = cache_miss;
  assign bus.refill_req  = refill_req;
  assign bus.refill_addr = {lat_addr[ADDR_W-1:OB+LB], (OB+LB)'(0)};
  assign bus.wb_valid    = !wb_empty;
  assign bus.wb_addr     = wb_addr_mem[rd_ptr];
  assign bus.wb_data     = wb_data_mem[rd_ptr];
  assign bus.wb_full     = wb_full;
  assign bus.wb_empty    = wb_empty;
endmodule

// File: tb/tb_line_cache.sv
// Bench for line_cache. A reference model predicts, for each access, whether it hits
// and what a read should return. The model keeps the latest value written to every
// word and the set of resident lines. A separate main-memory model supplies refill
// data and absorbs write-back pops.
module tb_line_cache;
  localparam int ADDR_W = 32, DATA_W = 32, LINE_WORDS = 16, INDEX_W = 8, WB_DEPTH = 4;

  logic cache_clk = 1'b0;
  logic rst;

  line_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) bus ();

  line_cache #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
    .INDEX_W(INDEX_W), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .cache_clk(cache_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 cache_clk = ~cache_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- models ----------------
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wb_entry_t;
  wb_entry_t   wbq[$];                       // writes expected out of the FIFO, in order
  logic [31:0] mem    [bit [31:0]];          // main memory contents as memory sees them
  logic [31:0] latest [bit [31:0]];          // value each word must read back
  bit          res_valid [256];
  logic [31:0] res_tag   [256];

  int wb_mode  = 2;                          // 0 hold, 1 random, 2 always ready
  bit wb_pulse = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] env_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return latest.exists(a) ? latest[a] : init_word(a);
  endfunction
  function automatic int line_index(input logic [31:0] a);
    return int'((a / 64) % 256);
  endfunction
  function automatic bit resident(input logic [31:0] a);
    return res_valid[line_index(a)] && (res_tag[line_index(a)] == a / 16384);
  endfunction

  task automatic clear_residency();
    foreach (res_valid[i]) res_valid[i] = 1'b0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a]    = v;
    latest[a] = v;
  endtask

  // ---------------- write-back sink ----------------
  initial begin
    wb_entry_t e;
    bus.wb_ready = 1'b0;
    forever begin
      @(negedge cache_clk);
      #3;
      case (wb_mode)
        0:       bus.wb_ready = 1'b0;
        1:       bus.wb_ready = 1'($urandom_range(0, 1));
        default: bus.wb_ready = 1'b1;
      endcase
      if (wb_pulse) begin
        bus.wb_ready = 1'b1;
        wb_pulse     = 1'b0;
      end
      if (bus.wb_ready && bus.wb_valid && !rst) begin
        check("wb_expected", 32'(wbq.size() > 0), 1);
        if (wbq.size() > 0) begin
          e = wbq.pop_front();
          check("wb_addr", bus.wb_addr, e.addr);
          check("wb_data", bus.wb_data, e.data);
          mem[e.addr] = e.data;
        end
      end
    end
  end

  // rsp_valid and cache_miss are mutually exclusive
  initial begin
    forever begin
      @(negedge cache_clk);
      #1;
      if (bus.rsp_valid || bus.cache_miss)
        check("rsp_miss_excl", 32'(bus.rsp_valid & bus.cache_miss), 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge cache_clk);
    rst = 1'b1; bus.req_valid = 1'b0; bus.inv = 1'b0; bus.refill_valid = 1'b0;
    repeat (cycles) @(negedge cache_clk);
    #1;
    check("rst_req_ready",  bus.req_ready,  0);
    check("rst_rsp_valid",  bus.rsp_valid,  0);
    check("rst_cache_miss", bus.cache_miss, 0);
    check("rst_refill_req", bus.refill_req, 0);
    check("rst_wb_valid",   bus.wb_valid,   0);
    check("rst_wb_empty",   bus.wb_empty,   1);
    rst = 1'b0;
    clear_residency();
    wbq.delete();
  endtask

  task automatic drain();
    int n = 0;
    wb_mode = 2;
    @(negedge cache_clk); #1;
    while (!bus.wb_empty && n < 200) begin @(negedge cache_clk); #1; n++; end
    check("drain_empty", bus.wb_empty, 1);
  endtask

  task automatic pulse_inv(input bit with_req);
    @(negedge cache_clk);
    bus.inv = 1'b1; bus.req_valid = with_req; bus.req_write = 1'b0; bus.req_addr = 32'h44;
    #1 check("inv_blocks_ready", bus.req_ready, 0);
    @(negedge cache_clk);
    bus.inv = 1'b0; bus.req_valid = 1'b0;
    #1 check("inv_no_accept", 32'(bus.rsp_valid | bus.cache_miss), 0);
    clear_residency();
  endtask

  // One complete CPU transaction, including refill servicing on a read miss
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output bit missed, output logic [31:0] raddr);
    bit exp_hit;
    int n;
    rdata = '0; missed = 1'b0; raddr = '0;
    exp_hit = resident(a);
    @(negedge cache_clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    #1; n = 0;
    while (!bus.req_ready && n < 400) begin @(negedge cache_clk); #1; n++; end
    check("accept", bus.req_ready, 1);
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    @(posedge cache_clk);
    if (w) begin
      wbq.push_back({a, d});
      latest[a] = d;
    end
    @(negedge cache_clk);
    bus.req_valid = 1'b0;
    #1;
    missed = bus.cache_miss;
    rdata  = bus.rsp_rdata;
    if (w) begin
      check("wr_ack",    bus.rsp_valid,  1);
      check("wr_nomiss", bus.cache_miss, 0);
      return;
    end
    check("rd_miss",     bus.cache_miss, 32'(!exp_hit));
    check("rd_rsp_next", bus.rsp_valid,  32'(exp_hit));
    if (!exp_hit) begin
      n = 0;
      @(negedge cache_clk); #1;
      check("refill_gate", bus.refill_req, bus.wb_empty);
      while (!bus.refill_req && n < 400) begin
        @(negedge cache_clk); #1; n++;
        check("refill_gate", bus.refill_req, bus.wb_empty);
      end
      check("refill_seen", bus.refill_req, 1);
      if (!bus.refill_req) return;
      raddr = bus.refill_addr;
      check("refill_addr", bus.refill_addr, a & ~32'h3F);
      bus.refill_valid = 1'b1;
      for (int k = 0; k < LINE_WORDS; k++)
        bus.refill_data[k*32 +: 32] = env_word((a & ~32'h3F) + 32'(k * 4));
      @(negedge cache_clk);
      bus.refill_valid = 1'b0;
      #1;
      check("fill_rsp",        bus.rsp_valid,  1);
      check("fill_drop_req",   bus.refill_req, 0);
      rdata = bus.rsp_rdata;
      res_valid[line_index(a)] = 1'b1;
      res_tag[line_index(a)]   = a / 16384;
    end
    check("rd_data", rdata, ref_word(a));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd, ra, a, d;
    bit ms, w;
    rst = 1'b1; bus.inv = 1'b0; bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.refill_valid = 1'b0; bus.refill_data = '0;
    clear_residency();
    do_reset(3);

    // Cold miss, refill, then hit
    preload(32'h44, 32'hDEADBEEF);
    xact(0, 32'h44, 0, rd, ms, ra);
    check("t21_miss", ms, 1);
    check("t21_refill_addr", ra, 32'h40);
    check("t21_data", rd, 32'hDEADBEEF);
    xact(0, 32'h44, 0, rd, ms, ra);
    check("t21_rehit", ms, 0);
    check("t21_rehit_data", rd, 32'hDEADBEEF);

    // Write hit goes to the FIFO and updates the line
    wb_mode = 0;
    xact(1, 32'h44, 32'h12345678, rd, ms, ra);
    @(negedge cache_clk); #1;
    check("t22_wb_valid", bus.wb_valid, 1);
    check("t22_wb_addr",  bus.wb_addr,  32'h44);
    check("t22_wb_data",  bus.wb_data,  32'h12345678);
    xact(0, 32'h44, 0, rd, ms, ra);
    check("t22_hit", ms, 0);
    check("t22_data", rd, 32'h12345678);
    drain();

    // A full FIFO stalls a write until one pop
    wb_mode = 0;
    for (int i = 0; i < 4; i++) xact(1, 32'h200 + 32'(i * 4), 32'hA000 + 32'(i), rd, ms, ra);
    @(negedge cache_clk); #1;
    check("t23_full", bus.wb_full, 1);
    fork
      xact(1, 32'h210, 32'h55, rd, ms, ra);
      begin
        @(negedge cache_clk);
        for (int i = 0; i < 3; i++) begin
          #2 check("t23_stall", bus.req_ready, 0);
          @(negedge cache_clk);
        end
        wb_pulse = 1'b1;
      end
    join
    @(negedge cache_clk); #1;
    check("t23_full_again", bus.wb_full, 1);
    drain();

    // A refill waits for pending writes to drain
    wb_mode = 0;
    xact(1, 32'h300, 32'hC0FFEE00, rd, ms, ra);
    xact(1, 32'h304, 32'hC0FFEE01, rd, ms, ra);
    fork
      xact(0, 32'h1000, 0, rd, ms, ra);
      begin
        repeat (3) @(negedge cache_clk);
        for (int i = 0; i < 4; i++) begin
          #2 check("t24_hold", bus.refill_req, 0);
          @(negedge cache_clk);
        end
        wb_mode = 2;
      end
    join
    check("t24_miss", ms, 1);
    check("t24_refill_addr", ra, 32'h1000);

    // Invalidate beats a simultaneous request
    xact(0, 32'h44, 0, rd, ms, ra);
    check("t25_hit", ms, 0);
    pulse_inv(1'b1);
    xact(0, 32'h44, 0, rd, ms, ra);
    check("t25_miss", ms, 1);

    // Reset abandons a refill in flight
    drain();
    pulse_inv(1'b0);
    @(negedge cache_clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h44;
    #1 check("t26_ready", bus.req_ready, 1);
    @(negedge cache_clk);
    bus.req_valid = 1'b0;
    #1 check("t26_miss", bus.cache_miss, 1);
    @(negedge cache_clk);
    #1 check("t26_refill_req", bus.refill_req, 1);
    rst = 1'b1;
    @(negedge cache_clk);
    #1 check("t26_rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    repeat (2) @(negedge cache_clk);
    #1;
    check("t26_req_dropped", bus.refill_req, 0);
    bus.refill_valid = 1'b1;
    bus.refill_data  = {LINE_WORDS{32'hBAD0BAD0}};
    @(negedge cache_clk);
    bus.refill_valid = 1'b0;
    clear_residency();
    wbq.delete();
    xact(0, 32'h44, 0, rd, ms, ra);
    check("t26_miss_again", ms, 1);
    check("t26_data", rd, 32'h12345678);

    // Randomized traffic over a few conflicting lines
    wb_mode = 1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 15) == 0) wb_mode = int'($urandom_range(1, 2));
      if ($urandom_range(0, 19) == 0) begin
        pulse_inv(1'($urandom_range(0, 1)));
      end else begin
        a = (32'($urandom_range(0, 2)) << 14) | (32'($urandom_range(0, 3)) << 6) |
            (32'($urandom_range(0, 15)) << 2);
        w = ($urandom_range(0, 9) < 4);
        d = $urandom;
        xact(w, a, d, rd, ms, ra);
      end
    end
    drain();
    check("end_queue_empty", 32'(wbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
